// File: rtl/approx_window_avg.sv
// Streaming window averager: accumulates 2^LOG2_N approximate sums, emits their mean
// on a held valid/ready output and counts delivered windows.
module approx_window_avg #(
    parameter int LOG2_N = 2,
    parameter int ROUND  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic [15:0] sum_in,
    input  logic        sum_valid,
    output logic        sum_ready,
    output logic [15:0] avg_out,
    output logic        avg_valid,
    input  logic        avg_ready,
    output logic [15:0] win_count
);

    localparam int ACC_W = 16 + LOG2_N;
    localparam logic [ACC_W-1:0] RND = (ROUND != 0) ? ACC_W'(2 ** (LOG2_N - 1)) : '0;
    localparam logic [LOG2_N-1:0] LAST_BEAT = '1;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [ACC_W-1:0]   r_acc;
    logic [LOG2_N-1:0]  r_cnt;
    logic [15:0]        r_avg;
    logic [15:0]        r_win;

    logic               w_accept;
    logic               w_last;
    logic               w_release;
    logic [ACC_W-1:0]   w_sum;
    logic [ACC_W-1:0]   w_total;
    logic [ACC_W-1:0]   w_quot;
    logic [15:0]        w_avg;

    assign sum_ready = (r_state == ACCUM);
    assign avg_valid = (r_state == HOLD);
    assign avg_out   = r_avg;
    assign win_count = r_win;

    assign w_accept  = (r_state == ACCUM) && sum_valid;
    assign w_last    = w_accept && (r_cnt == LAST_BEAT);
    assign w_release = (r_state == HOLD) && avg_ready;

    // Accumulator is wide enough that N full-scale beats plus the rounding term never wrap.
    assign w_sum   = r_acc + ACC_W'(sum_in);
    assign w_total = w_sum + RND;
    assign w_quot  = w_total >> LOG2_N;
    assign w_avg   = (|w_quot[ACC_W-1:16]) ? 16'hFFFF : w_quot[15:0];

    always_comb begin
        w_next = r_state;
        case (r_state)
            ACCUM:   if (w_last) w_next = HOLD;
            HOLD:    if (avg_ready) w_next = ACCUM;
            default: w_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_win   <= '0;
        end else if (clear) begin
            r_state <= ACCUM;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_avg   <= '0;
            r_win   <= '0;
        end else begin
            r_state <= w_next;
            if (w_last) begin
                r_avg <= w_avg;
                r_acc <= '0;
                r_cnt <= '0;
            end else if (w_accept) begin
                r_acc <= w_sum;
                r_cnt <= r_cnt + LOG2_N'(1);
            end
            if (w_release) begin
                r_win <= r_win + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_approx_window_avg.sv
// Bench for approx_window_avg: truncating and rounding instances share one input stream
// and are compared each cycle against a queue-based window-mean model.
module tb_approx_window_avg;

    localparam int LOG2_N = 2;
    localparam int N      = 1 << LOG2_N;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic [15:0] sum_in;
    logic        sum_valid;
    logic        avg_ready;

    logic        sumReady0, avgValid0, sumReady1, avgValid1;
    logic [15:0] avgOut0, winCount0, avgOut1, winCount1;

    approx_window_avg #(.LOG2_N(LOG2_N), .ROUND(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sumReady0),
        .avg_out(avgOut0), .avg_valid(avgValid0), .avg_ready(avg_ready),
        .win_count(winCount0)
    );

    approx_window_avg #(.LOG2_N(LOG2_N), .ROUND(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .sum_in(sum_in), .sum_valid(sum_valid), .sum_ready(sumReady1),
        .avg_out(avgOut1), .avg_valid(avgValid1), .avg_ready(avg_ready),
        .win_count(winCount1)
    );

    always #5 clk = ~clk;

    int nCompared   = 0;
    int nMismatched = 0;

    int mBeats[$];
    bit mHold;
    int mAvgTrunc;
    int mAvgRound;
    int mWin;

    typedef struct {
        int beats[N];
        int expTrunc;
        int expRound;
    } vector_t;

    vector_t vectors[6];

    function automatic void modelReset();
        mBeats.delete();
        mHold     = 1'b0;
        mAvgTrunc = 0;
        mAvgRound = 0;
        mWin      = 0;
    endfunction

    // Advances the reference by one rising edge using the inputs currently applied.
    function automatic void modelEdge();
        longint total;
        if (!rst_n) return;
        if (clear) begin
            modelReset();
            return;
        end
        if (!mHold) begin
            if (sum_valid) begin
                mBeats.push_back(int'(sum_in));
                if (mBeats.size() == N) begin
                    total = 0;
                    foreach (mBeats[k]) total += mBeats[k];
                    mAvgTrunc = int'(total / N);
                    mAvgRound = int'((total + N / 2) / N);
                    if (mAvgTrunc > 65535) mAvgTrunc = 65535;
                    if (mAvgRound > 65535) mAvgRound = 65535;
                    mBeats.delete();
                    mHold = 1'b1;
                end
            end
        end else if (avg_ready) begin
            mWin  = (mWin + 1) % 65536;
            mHold = 1'b0;
        end
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutputs();
        checkOutput("sumReady0", int'(sumReady0), int'(!mHold));
        checkOutput("sumReady1", int'(sumReady1), int'(!mHold));
        checkOutput("avgValid0", int'(avgValid0), int'(mHold));
        checkOutput("avgValid1", int'(avgValid1), int'(mHold));
        checkOutput("avgOutTrunc", int'(avgOut0), mAvgTrunc);
        checkOutput("avgOutRound", int'(avgOut1), mAvgRound);
        checkOutput("winCount0", int'(winCount0), mWin);
        checkOutput("winCount1", int'(winCount1), mWin);
    endtask

    // Applies inputs just after an edge, lets the next edge happen, then checks.
    task automatic applyStimulus(input bit valid, input int data, input bit ready, input bit clr);
        sum_valid = valid;
        sum_in    = 16'(data);
        avg_ready = ready;
        clear     = clr;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    initial begin
        vectors[0] = '{beats: '{10, 20, 30, 40},                     expTrunc: 25,    expRound: 25};
        vectors[1] = '{beats: '{1, 2, 2, 2},                         expTrunc: 1,     expRound: 2};
        vectors[2] = '{beats: '{65535, 65535, 65535, 65535},         expTrunc: 65535, expRound: 65535};
        vectors[3] = '{beats: '{5, 5, 5, 7},                         expTrunc: 5,     expRound: 6};
        vectors[4] = '{beats: '{0, 0, 0, 1},                         expTrunc: 0,     expRound: 0};
        vectors[5] = '{beats: '{65532, 65532, 65532, 65534},         expTrunc: 65532, expRound: 65533};

        rst_n = 1'b0; clear = 1'b0; sum_in = '0; sum_valid = 1'b0; avg_ready = 1'b0;
        modelReset();
        #1;
        checkOutputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutputs();

        $display("[TB] table-driven windows");
        foreach (vectors[v]) begin
            for (int j = 0; j < N; j++) applyStimulus(1'b1, vectors[v].beats[j], 1'b1, 1'b0);
            checkOutput("tableAvgTrunc", int'(avgOut0), vectors[v].expTrunc);
            checkOutput("tableAvgRound", int'(avgOut1), vectors[v].expRound);
            checkOutput("tableSumReadyLow", int'(sumReady0), 0);
            applyStimulus(1'b0, 0, 1'b1, 1'b0);
            checkOutput("tableWinCount", int'(winCount0), v + 1);
        end

        $display("[TB] backpressure");
        for (int j = 0; j < N; j++) applyStimulus(1'b1, 100 + j, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b1, 999, 1'b0, 1'b0);
            checkOutput("bpAvgStable", int'(avgOut0), (100 + 101 + 102 + 103) / N);
        end
        applyStimulus(1'b1, 999, 1'b1, 1'b0);
        checkOutput("bpNoBeatInHandshake", int'(mBeats.size()), 0);
        for (int j = 0; j < N; j++) applyStimulus(1'b1, 8, 1'b1, 1'b0);
        checkOutput("bpNextWindow", int'(avgOut0), 8);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);

        $display("[TB] clear mid-window and in HOLD");
        applyStimulus(1'b1, 100, 1'b1, 1'b0);
        applyStimulus(1'b1, 100, 1'b1, 1'b0);
        applyStimulus(1'b1, 100, 1'b1, 1'b1);
        checkOutput("clearWinZero", int'(winCount0), 0);
        for (int j = 0; j < N; j++) applyStimulus(1'b1, 4, 1'b0, 1'b0);
        checkOutput("clearPartialDropped", int'(avgOut0), 4);
        applyStimulus(1'b1, 7, 1'b1, 1'b1);
        checkOutput("clearInHoldValid", int'(avgValid0), 0);
        checkOutput("clearInHoldWin", int'(winCount1), 0);
        checkOutput("clearInHoldAvg", int'(avgOut1), 0);

        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 500, 1'b1, 1'b0);
        applyStimulus(1'b1, 600, 1'b1, 1'b0);
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutputs();
        applyStimulus(1'b1, 700, 1'b1, 1'b0);
        applyStimulus(1'b1, 700, 1'b1, 1'b0);
        rst_n = 1'b1;
        for (int j = 0; j < N; j++) applyStimulus(1'b1, 12, 1'b1, 1'b0);
        checkOutput("resetNoBeatsCounted", int'(avgOut0), 12);
        applyStimulus(1'b0, 0, 1'b1, 1'b0);

        $display("[TB] win_count wrap");
        for (int j = 0; j < N; j++) applyStimulus(1'b1, 3, 1'b0, 1'b0);
        force dut0.r_win = 16'hFFFF;
        force dut1.r_win = 16'hFFFF;
        #1;
        release dut0.r_win;
        release dut1.r_win;
        mWin = 65535;
        #1;
        checkOutputs();
        applyStimulus(1'b0, 0, 1'b1, 1'b0);
        checkOutput("wrapWinCount", int'(winCount0), 0);

        $display("[TB] randomized stream");
        for (int c = 0; c < 600; c++) begin
            applyStimulus($urandom_range(0, 9) < 7,
                          int'($urandom_range(0, 65535) & 32'hFFFC),
                          $urandom_range(0, 9) < 6,
                          $urandom_range(0, 99) < 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/approx_window_avg.md
# approx_window_avg

Streaming window averager downstream of the 16-bit approximate adder in the image-processing datapath. Consumes one approximate sum per valid/ready handshake, accumulates exactly 2^LOG2_N beats and emits their mean on a held valid/ready output. It also counts completed windows. It turns per-pixel-pair approximate sums into block-averaged intensities for the next filter stage.

## Interface

Parameters:
- LOG2_N, default 2: window size exponent, N = 2^LOG2_N beats per window; legal range 1..8.
- ROUND, default 0: 0 = truncate on divide; 1 = round-half-up (add 2^(LOG2_N-1) before shift).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- clear  input  1  synchronous flush, highest priority after reset.
- sum_in  input  16  unsigned sum from the approximate adder (bits [1:0] arrive as 0; treated as ordinary data).
- sum_valid  input  1  sum_in valid.
- sum_ready  output  1  block accepts sum_in this cycle.
- avg_out  output  16  window mean, unsigned.
- avg_valid  output  1  avg_out valid, held until accepted.
- avg_ready  input  1  downstream accepts avg_out.
- win_count  output  16  number of windows delivered since reset/clear, wraps 0xFFFF -> 0x0000.

## Operation

- Internal state: acc (16+LOG2_N bits), beat counter cnt (LOG2_N bits), FSM {ACCUM, HOLD}.
- ACCUM: sum_ready = 1, avg_valid = 0. On sum_valid && sum_ready: if cnt < N-1, acc <= acc + sum_in, cnt <= cnt + 1; if cnt == N-1 (last beat), avg_out <= ((acc + sum_in + RND) >> LOG2_N), acc <= 0, cnt <= 0, state <= HOLD.
- RND = 2^(LOG2_N-1) when ROUND = 1, else 0. Result is saturated to 0xFFFF; by construction it never exceeds 0xFFFF, but saturation logic is required.
- acc width 16+LOG2_N: no overflow possible; the add uses full width and no wrap.
- HOLD: sum_ready = 0, avg_valid = 1, avg_out stable. On avg_ready: win_count <= win_count + 1 (mod 2^16), state <= ACCUM. A new beat is not accepted in the handshake cycle.
- clear (synchronous, 1 cycle): acc <= 0, cnt <= 0, avg_valid <= 0, avg_out <= 0, win_count <= 0, state <= ACCUM. Any partial window or pending output is discarded. clear overrides a coincident input or output handshake; the beat presented with clear is dropped and a coincident avg_ready does not count.
- rst_n low (any time, including mid-window or in HOLD): same values as clear, applied asynchronously.
- sum_valid while in HOLD: ignored (sum_ready = 0); upstream holds data.

## Timing

- Reset values: sum_ready = 1 (combinational from state ACCUM), avg_valid = 0, avg_out = 0x0000, win_count = 0x0000.
- sum_ready and avg_valid are decoded from the registered state only; no combinational path from avg_ready or sum_valid to any output.
- Latency: avg_valid rises the cycle after the N-th input handshake edge.
- Minimum window period: N + 1 cycles (N accept cycles + 1 HOLD cycle with avg_ready = 1).
- win_count updates on the edge that completes the output handshake; it is visible the following cycle.
- avg_out changes only on the edge entering HOLD, or on clear/reset.

## Test plan

- Reset: hold rst_n low mid-stream with sum_valid = 1 -> avg_valid = 0, avg_out = 0, win_count = 0 immediately; sum_ready = 1 after release; no beats counted during reset.
- Basic, LOG2_N = 2, ROUND = 0: beats 10, 20, 30, 40 back-to-back with avg_ready = 1 -> avg_out = 25 with avg_valid one cycle after beat 4; sum_ready = 0 that cycle; win_count = 1 next cycle.
- Rounding, LOG2_N = 2: beats 1, 2, 2, 2 (sum 7) -> avg_out = 1 when ROUND = 0, avg_out = 2 when ROUND = 1. Beats 0xFFFF ×4 -> 0xFFFF for both settings.
- Backpressure: after a window completes, keep avg_ready = 0 for 5 cycles -> avg_out stable, avg_valid = 1, sum_ready = 0, and held sum_valid beats are not consumed. Then avg_ready = 1 for 1 cycle -> the next beat is accepted no earlier than the following cycle.
- Clear mid-window: 2 beats of 100, then clear, then 4 beats of 4 -> avg_out = 4 (partial window discarded). A clear asserted in HOLD drops avg_valid the next cycle and zeroes win_count.
- Wrap: preload by running 65536 windows (or force win_count = 0xFFFF) -> the next output handshake yields win_count = 0x0000.
